// File: rtl/rr_arb4_16.sv
// Four-source round-robin arbiter feeding a small output FIFO (WIDTH-bit words, DEPTH entries).
// Latency: a word granted at edge N is on OUT after edge N when the FIFO was empty; grant/s are combinational.
// Backpressure: grants only while a slot is free or the head is popped this cycle; all readies low otherwise.
module rr_arb4_16 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         W,
  input  logic [WIDTH-1:0]         X,
  input  logic [WIDTH-1:0]         Y,
  input  logic [WIDTH-1:0]         Z,
  input  logic                     w_valid,
  input  logic                     x_valid,
  input  logic                     y_valid,
  input  logic                     z_valid,
  output logic                     w_ready,
  output logic                     x_ready,
  output logic                     y_ready,
  output logic                     z_ready,
  output logic [1:0]               s,
  output logic [WIDTH-1:0]         OUT,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Arbitration state: last winner (lowest priority next) and the index shown on s when idle.
  logic [1:0]       last_q, last_d;
  logic [1:0]       s_q, s_d;

  // FIFO state.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Combinational arbitration signals.
  logic [3:0]       valid_vec;
  logic [3:0]       ready_vec;
  logic [1:0]       cand;
  logic [1:0]       gnt_idx;
  logic             found;
  logic             space;
  logic             gnt_vld;
  logic             pop;
  logic [WIDTH-1:0] din;

  assign valid_vec = {z_valid, y_valid, x_valid, w_valid};

  // Head is always a registered value, so nothing on the input side reaches OUT combinationally.
  assign out_valid = (count_q != '0);
  assign OUT       = mem_q[rd_ptr_q];
  assign count     = count_q;

  // A pop in the same cycle frees a slot, which keeps full-rate streaming when the FIFO is full.
  assign pop   = out_valid & out_ready;
  assign space = (count_q < DEPTH_C) | pop;

  // Rotating priority search starting just after the previous winner.
  always_comb begin
    found   = 1'b0;
    gnt_idx = last_q;
    cand    = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && valid_vec[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Grant qualification and output decode; reset holds every ready low even with valids high.
  always_comb begin
    gnt_vld   = rst_n & space & found;
    ready_vec = 4'b0000;
    s         = s_q;
    if (gnt_vld) begin
      ready_vec = 4'b0001 << gnt_idx;
      s         = gnt_idx;
    end
    w_ready = ready_vec[0];
    x_ready = ready_vec[1];
    y_ready = ready_vec[2];
    z_ready = ready_vec[3];
  end

  // Data select for the winning channel.
  always_comb begin
    din = W;
    case (gnt_idx)
      2'd0:    din = W;
      2'd1:    din = X;
      2'd2:    din = Y;
      default: din = Z;
    endcase
  end

  // Next-state for the round-robin pointer and the idle value of s.
  always_comb begin
    last_d = last_q;
    s_d    = s_q;
    if (gnt_vld) begin
      last_d = gnt_idx;
      s_d    = gnt_idx;
    end
  end

  // Next-state for FIFO storage, pointers and occupancy; push and pop together leave count unchanged.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (gnt_vld) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({gnt_vld, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Arbitration registers; last=3 on reset gives W first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 2'd3;
      s_q    <= 2'd0;
    end else begin
      last_q <= last_d;
      s_q    <= s_d;
    end
  end

  // FIFO registers; reset discards contents and zeroes the head word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule
